// File: rtl/ppu_muldiv_pkg.sv
// Shared definitions for the PPU HI/LO multiply/divide sequencer:
// HI/LO op encodings, sequencer state constants and the divider iteration count.
package ppu_muldiv_pkg;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;
   localparam logic [2:0] OP_MFHI  = 3'b110;
   localparam logic [2:0] OP_MFLO  = 3'b111;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MUL  = 2'd1;
   localparam logic [1:0] ST_DIV  = 2'd2;
   localparam logic [1:0] ST_FIX  = 2'd3;

   localparam int DIV_ITER = 32;

   function automatic logic is_mul_op(input logic [2:0] op);
      return (op == OP_MULT) || (op == OP_MULTU);
   endfunction

   function automatic logic is_div_op(input logic [2:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/ppu_div_iter.sv
// Restoring divider datapath: holds the partial remainder, the quotient
// shift register and the divisor. One quotient bit is produced per 'step'.
// Operands are unsigned magnitudes; sign handling lives in the parent.
module ppu_div_iter
   import ppu_muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] dsr_q;
   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] trial;
   logic             fits;

   // Trial subtraction: shift the next dividend bit into the remainder and
   // see whether the divisor fits. The shifted value needs one extra bit.
   always_comb begin
      shifted = {rem_q, quo_q[WIDTH-1]};
      fits    = (shifted >= {1'b0, dsr_q});
      trial   = shifted[WIDTH-1:0] - dsr_q;
   end

   // Load fresh magnitudes, or retire one restoring iteration per step.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         quo_q <= '0;
         rem_q <= '0;
         dsr_q <= '0;
      end else if (load) begin
         quo_q <= dividend;
         rem_q <= '0;
         dsr_q <= divisor;
      end else if (step) begin
         if (fits) begin
            rem_q <= trial;
            quo_q <= {quo_q[WIDTH-2:0], 1'b1};
         end else begin
            rem_q <= shifted[WIDTH-1:0];
            quo_q <= {quo_q[WIDTH-2:0], 1'b0};
         end
      end
   end

   assign quotient  = quo_q;
   assign remainder = rem_q;

endmodule

// File: rtl/ppu_hilo_muldiv_sequencer.sv
// HI/LO multiply/divide sequencer for the PPU EX stage.
// Runs MULT/MULTU over MUL_CYCLES cycles and DIV/DIVU as 32 restoring
// iterations plus one sign-fix cycle; services MTHI/MTLO/MFHI/MFLO and
// stalls the front of the pipe while an operation is in flight.
// Optional build macro: PPU_MULDIV_EARLY_OUT_EN -- trivially-zero multiplies
// and zero-dividend divides complete at acceptance with no busy cycles.
module ppu_hilo_muldiv_sequencer
   import ppu_muldiv_pkg::*;
#(
   parameter int MUL_CYCLES = 4,
   parameter int WIDTH      = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ex_valid,
   input  logic [2:0]       ex_op,
   input  logic             flush,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   output logic             stall,
   output logic             busy,
   output logic [WIDTH-1:0] mf_data,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_zero
);

   localparam logic [5:0] MUL_INIT = 6'(MUL_CYCLES - 1);
   localparam logic [5:0] DIV_INIT = 6'(DIV_ITER - 1);

   logic [1:0]         state;
   logic [5:0]         counter;
   logic [WIDTH-1:0]   op_a;
   logic [WIDTH-1:0]   op_b;
   logic               mul_signed;
   logic               neg_q;
   logic               neg_r;

   logic               accept;
   logic               op_is_mul;
   logic               op_is_div;
   logic               rt_zero;
   logic               early_out;
   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   abs_a;
   logic [WIDTH-1:0]   abs_b;
   logic               div_load;
   logic               div_step;
   logic [WIDTH-1:0]   div_quot;
   logic [WIDTH-1:0]   div_rem;
   logic [WIDTH-1:0]   quot_fix;
   logic [WIDTH-1:0]   rem_fix;
   logic [2*WIDTH-1:0] ext_a;
   logic [2*WIDTH-1:0] ext_b;
   logic [2*WIDTH-1:0] product;

   // Acceptance decode and operand magnitudes for the divider. A flush
   // blocks acceptance even in IDLE, so a squashed instruction never issues.
   always_comb begin
      accept    = ex_valid && (state == ST_IDLE) && !flush;
      op_is_mul = is_mul_op(ex_op);
      op_is_div = is_div_op(ex_op);
      rt_zero   = (rt_val == '0);
      a_neg     = (ex_op == OP_DIV) && rs_val[WIDTH-1];
      b_neg     = (ex_op == OP_DIV) && rt_val[WIDTH-1];
      abs_a     = a_neg ? (-rs_val) : rs_val;
      abs_b     = b_neg ? (-rt_val) : rt_val;
`ifdef PPU_MULDIV_EARLY_OUT_EN
      early_out = (op_is_mul && ((rs_val == '0) || rt_zero)) ||
                  (op_is_div && (rs_val == '0) && !rt_zero);
`else
      early_out = 1'b0;
`endif
      div_load  = accept && op_is_div && !rt_zero && !early_out;
      div_step  = (state == ST_DIV) && !flush;
   end

   // Product of the latched operands; sign extension selects MULT vs MULTU,
   // and the low 2*WIDTH bits of the extended product are the exact result.
   always_comb begin
      ext_a   = {{WIDTH{mul_signed & op_a[WIDTH-1]}}, op_a};
      ext_b   = {{WIDTH{mul_signed & op_b[WIDTH-1]}}, op_b};
      product = ext_a * ext_b;
   end

   // Sign fix-up: quotient negative when operand signs differ, remainder
   // follows the dividend. 0x80000000 / -1 wraps naturally to 0x80000000.
   always_comb begin
      quot_fix = neg_q ? (-div_quot) : div_quot;
      rem_fix  = neg_r ? (-div_rem)  : div_rem;
   end

   ppu_div_iter #(
      .WIDTH (WIDTH)
   ) u_div_iter (
      .clk       (clk),
      .reset     (reset),
      .load      (div_load),
      .step      (div_step),
      .dividend  (abs_a),
      .divisor   (abs_b),
      .quotient  (div_quot),
      .remainder (div_rem)
   );

   // Sequencer FSM plus HI/LO registers. Flush of an in-flight op wins over
   // everything and leaves HI/LO holding their pre-op values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         counter    <= '0;
         op_a       <= '0;
         op_b       <= '0;
         mul_signed <= 1'b0;
         neg_q      <= 1'b0;
         neg_r      <= 1'b0;
         hi         <= '0;
         lo         <= '0;
         div_zero   <= 1'b0;
      end else begin
         div_zero <= 1'b0;
         if (flush && (state != ST_IDLE)) begin
            state   <= ST_IDLE;
            counter <= '0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (accept) begin
                     if (early_out) begin
                        hi <= '0;
                        lo <= '0;
                     end else begin
                        case (ex_op)
                           OP_MULT, OP_MULTU: begin
                              op_a       <= rs_val;
                              op_b       <= rt_val;
                              mul_signed <= (ex_op == OP_MULT);
                              counter    <= MUL_INIT;
                              state      <= ST_MUL;
                           end
                           OP_DIV, OP_DIVU: begin
                              if (rt_zero) begin
                                 div_zero <= 1'b1;
                              end else begin
                                 neg_q   <= a_neg ^ b_neg;
                                 neg_r   <= a_neg;
                                 counter <= DIV_INIT;
                                 state   <= ST_DIV;
                              end
                           end
                           OP_MTHI: hi <= rs_val;
                           OP_MTLO: lo <= rs_val;
                           default: ;
                        endcase
                     end
                  end
               end
               ST_MUL: begin
                  if (counter == '0) begin
                     {hi, lo} <= product;
                     state    <= ST_IDLE;
                  end else begin
                     counter <= counter - 6'd1;
                  end
               end
               ST_DIV: begin
                  if (counter == '0) begin
                     state <= ST_FIX;
                  end else begin
                     counter <= counter - 6'd1;
                  end
               end
               ST_FIX: begin
                  hi    <= rem_fix;
                  lo    <= quot_fix;
                  state <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   // Pipeline-facing status and the MFHI/MFLO read mux.
   always_comb begin
      busy    = (state != ST_IDLE);
      stall   = ex_valid && (state != ST_IDLE);
      mf_data = (ex_op == OP_MFHI) ? hi : lo;
   end

endmodule
